// File: rtl/v68k_pkg.sv
// Shared V68k definitions: arbiter state encoding and handshake levels.
package v68k_pkg;

  // Arbiter state encoding; the raw value is exported on ARB_STATE for debug.
  typedef enum logic [2:0] {
    CPU_OWN    = 3'd0,
    GRANT_PEND = 3'd1,
    GRANTED    = 3'd2,
    EXT_OWN    = 3'd3,
    RELEASE    = 3'd4
  } arb_state_t;

  // Handshake line levels (all arbitration lines are active-high here).
  localparam logic ASSERTED = 1'b1;
  localparam logic NEGATED  = 1'b0;

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbitration handshake bundle between the core, external masters and the arbiter.
interface bus_arbiter_if;
  import v68k_pkg::*;

  logic       BR;
  logic       BGACK;
  logic       CPU_BUSY;
  logic       CPU_LOCK;
  logic       BG;
  logic       CPU_GNT;
  logic       BUS_EN;
  arb_state_t ARB_STATE;

  // Arbiter side: consumes requests and core status, drives grants.
  modport slave (
    input  BR, BGACK, CPU_BUSY, CPU_LOCK,
    output BG, CPU_GNT, BUS_EN, ARB_STATE
  );

  // Environment side: external masters plus the core's bus sequencer.
  modport master (
    output BR, BGACK, CPU_BUSY, CPU_LOCK,
    input  BG, CPU_GNT, BUS_EN, ARB_STATE
  );

endinterface

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for an asynchronous single-bit input, cleared by reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic D,
  output logic Q
);

  logic [STAGES-1:0] stage_reg;

  // Shift the raw input through the chain; only the last stage is used downstream.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= {stage_reg[STAGES-2:0], D};
    end
  end

  assign Q = stage_reg[STAGES-1];

endmodule

// File: rtl/bus_arbiter.sv
// 68000-style BR/BG/BGACK bus-ownership controller. Decides when the core may
// start a bus cycle and when it may drive the address/data/strobe pins.
module bus_arbiter
  import v68k_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int GRANT_TIMEOUT = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  bus_arbiter_if.slave  bus
);

  // A zero timeout disables the counter, but keep it at least one bit wide.
  localparam int CNT_W = (GRANT_TIMEOUT > 0) ? $clog2(GRANT_TIMEOUT + 1) : 1;
  // The counter holds the number of completed GRANTED cycles, so the grant is
  // withdrawn at the edge where the count is one short of the limit.
  localparam logic [CNT_W-1:0] CNT_LAST =
    (GRANT_TIMEOUT > 0) ? CNT_W'(GRANT_TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             br_s;
  logic             bgack_s;
  arb_state_t       state_reg;
  arb_state_t       state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             timeout_hit;
  logic             bg_reg;
  logic             cpu_gnt_reg;
  logic             bus_en_reg;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_br (
    .CLK   (CLK),
    .RESET (RESET),
    .D     (bus.BR),
    .Q     (br_s)
  );

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync_bgack (
    .CLK   (CLK),
    .RESET (RESET),
    .D     (bus.BGACK),
    .Q     (bgack_s)
  );

  assign timeout_hit = (GRANT_TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  // Next-state decision; in GRANTED an acknowledge beats loss of request and timeout.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CPU_OWN: begin
        if (br_s == ASSERTED) state_next = GRANT_PEND;
      end
      GRANT_PEND: begin
        // A cycle started as CPU_GNT fell shows up as CPU_BUSY here, so this
        // state always lasts at least one cycle.
        if (br_s == NEGATED)                             state_next = CPU_OWN;
        else if (bus.CPU_BUSY == NEGATED && bus.CPU_LOCK == NEGATED) state_next = GRANTED;
      end
      GRANTED: begin
        if (bgack_s == ASSERTED)  state_next = EXT_OWN;
        else if (br_s == NEGATED) state_next = RELEASE;
        else if (timeout_hit)     state_next = RELEASE;
      end
      EXT_OWN: begin
        if (bgack_s == NEGATED) state_next = (br_s == ASSERTED) ? GRANTED : RELEASE;
      end
      RELEASE: begin
        state_next = CPU_OWN;
      end
      default: begin
        state_next = CPU_OWN;
      end
    endcase
  end

  // State, grant-age counter and outputs decoded from the state being entered.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg   <= CPU_OWN;
      cnt_reg     <= '0;
      bg_reg      <= NEGATED;
      cpu_gnt_reg <= ASSERTED;
      bus_en_reg  <= ASSERTED;
    end else begin
      state_reg <= state_next;
      if (state_reg == GRANTED) begin
        cnt_reg <= (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
      end else begin
        cnt_reg <= '0;
      end
      bg_reg      <= (state_next == GRANTED);
      cpu_gnt_reg <= (state_next == CPU_OWN);
      bus_en_reg  <= (state_next == CPU_OWN) || (state_next == GRANT_PEND);
    end
  end

  assign bus.BG        = bg_reg;
  assign bus.CPU_GNT   = cpu_gnt_reg;
  assign bus.BUS_EN    = bus_en_reg;
  assign bus.ARB_STATE = state_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized scoreboard bench for bus_arbiter with directed handshake scenarios.
module tb_bus_arbiter;
  import v68k_pkg::*;

  localparam int S = 2;
  localparam int T = 16;

  typedef struct packed {
    logic [2:0] st;
    logic       bg;
    logic       gnt;
    logic       en;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;
  exp_t exp_q[$];

  // Reference model: ownership phase, cycles spent granted, and what the
  // arbiter will have seen of BR/BGACK (each input arrives S edges late).
  arb_state_t m_state;
  int         m_age;
  logic       br_hist[$];
  logic       bgack_hist[$];

  always #5 CLK = ~CLK;

  bus_arbiter_if bus();

  bus_arbiter #(.SYNC_STAGES(S), .GRANT_TIMEOUT(T)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  function automatic exp_t outputs_for(arb_state_t s);
    exp_t e;
    e.st  = s;
    e.bg  = (s == GRANTED);
    e.gnt = (s == CPU_OWN);
    e.en  = (s == CPU_OWN) || (s == GRANT_PEND);
    return e;
  endfunction

  task automatic model_reset();
    m_state = CPU_OWN;
    m_age   = 0;
    br_hist.delete();
    bgack_hist.delete();
    for (int i = 0; i < S; i++) begin
      br_hist.push_back(1'b0);
      bgack_hist.push_back(1'b0);
    end
  endtask

  // One rising edge of the reference behaviour with the given pin levels.
  task automatic model_edge(input logic br, input logic bgack,
                            input logic busy, input logic lock);
    logic brs, bks;
    brs = br_hist.pop_front();
    bks = bgack_hist.pop_front();
    br_hist.push_back(br);
    bgack_hist.push_back(bgack);
    case (m_state)
      CPU_OWN:    if (brs) m_state = GRANT_PEND;
      GRANT_PEND: begin
        if (!brs) m_state = CPU_OWN;
        else if (!busy && !lock) begin m_state = GRANTED; m_age = 0; end
      end
      GRANTED: begin
        m_age = m_age + 1;
        if (bks)                       m_state = EXT_OWN;
        else if (!brs)                 m_state = RELEASE;
        else if (T != 0 && m_age >= T) m_state = RELEASE;
      end
      EXT_OWN: begin
        if (!bks) begin
          if (brs) begin m_state = GRANTED; m_age = 0; end
          else m_state = RELEASE;
        end
      end
      default: m_state = CPU_OWN;
    endcase
  endtask

  task automatic check_out(input string name, input exp_t e);
    exp_t got;
    got = {bus.ARB_STATE, bus.BG, bus.CPU_GNT, bus.BUS_EN};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s t=%0t: got st=%0d bg=%b gnt=%b en=%b, want st=%0d bg=%b gnt=%b en=%b",
               name, $time, got.st, got.bg, got.gnt, got.en, e.st, e.bg, e.gnt, e.en);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t: got %b want %b", name, $time, got, want);
    end
  endtask

  // Drive one cycle of pins at the falling edge and queue the expected response.
  task automatic cycle(input logic rst, input logic br, input logic bgack,
                       input logic busy, input logic lock);
    @(negedge CLK);
    RESET        = rst;
    bus.BR       = br;
    bus.BGACK    = bgack;
    bus.CPU_BUSY = busy;
    bus.CPU_LOCK = lock;
    if (!rst) begin
      #1;
      check_out("async_reset", outputs_for(CPU_OWN));
      model_reset();
    end else begin
      model_edge(br, bgack, busy, lock);
    end
    exp_q.push_back(outputs_for(m_state));
  endtask

  // Monitor: after each rising edge compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        $display("txn %0d st=%0d bg=%b gnt=%b en=%b exp_st=%0d", txn,
                 bus.ARB_STATE, bus.BG, bus.CPU_GNT, bus.BUS_EN, e.st);
        check_out("cycle", e);
      end
    end
  end

  initial begin
    int   bg_count;
    int   hold;
    logic r_br, r_bgack, r_lock;

    RESET        = 1'b1;
    bus.BR       = 1'b0;
    bus.BGACK    = 1'b0;
    bus.CPU_BUSY = 1'b0;
    bus.CPU_LOCK = 1'b0;
    model_reset();
    #2 RESET = 1'b0;
    #1 check_out("reset_state", outputs_for(CPU_OWN));
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Idle grant: BR rises after edge 0, BG must appear at edge S+2.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge CLK);
      #2;
      if (i == 2) begin
        check_bit("idle_pend_bg", bus.BG, 1'b0);
        check_bit("idle_pend_gnt", bus.CPU_GNT, 1'b0);
      end
      if (i == 3) begin
        check_bit("idle_grant_bg", bus.BG, 1'b1);
        check_bit("idle_grant_en", bus.BUS_EN, 1'b0);
      end
    end

    // Full tenure: acknowledge after two granted cycles, hold, then release all.
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Busy deferral, then RMW lock with busy toggling.
    for (int i = 0; i < 6; i++)  cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)  cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)  cycle(1'b1, 1'b1, 1'b0, logic'(i % 2 == 0), 1'b1);
    for (int i = 0; i < 3; i++)  cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++)  cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout: BR held, no acknowledge; BG must be high for exactly T cycles
    // before the RELEASE / CPU_OWN / GRANT_PEND round trip.
    bg_count = 0;
    for (int i = 0; i < 22; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge CLK);
      #2;
      if (bus.BG) bg_count++;
    end
    checks++;
    if (bg_count != T) begin
      errors++;
      $display("FAIL timeout_len: BG high %0d cycles, want %0d", bg_count, T);
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an external tenure.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.ARB_STATE !== EXT_OWN) begin
      errors++;
      $display("FAIL ext_own_before_reset: got st=%0d want %0d", bus.ARB_STATE, EXT_OWN);
    end
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized bursts: requests/acks held for random stretches, busy per cycle,
    // with an occasional reset.
    hold    = 0;
    r_br    = 1'b0;
    r_bgack = 1'b0;
    r_lock  = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if (hold == 0) begin
        hold    = $urandom_range(1, 24);
        r_br    = ($urandom_range(0, 3) != 0);
        r_bgack = ($urandom_range(0, 2) == 0);
        r_lock  = ($urandom_range(0, 5) == 0);
      end
      hold--;
      cycle(logic'($urandom_range(0, 299) != 0), r_br, r_bgack,
            logic'($urandom_range(0, 2) == 0), r_lock);
    end

    @(posedge CLK);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
